// File: rtl/data_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_controller
//  Description : Arbitrates per-thread LSU read/write requests onto a single
//                downstream memory read channel and write channel. One
//                transaction is outstanding at a time; consumers are served
//                round-robin starting from the port after the last one served.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_controller #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                               clk,
    input  logic                               reset,

    // consumer read ports
    input  logic [NUM_CONSUMERS-1:0]           consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]           consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_read_data,

    // consumer write ports
    input  logic [NUM_CONSUMERS-1:0]           consumer_write_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0] consumer_write_address,
    input  logic [NUM_CONSUMERS*DATA_BITS-1:0] consumer_write_data,
    output logic [NUM_CONSUMERS-1:0]           consumer_write_ready,

    // downstream read channel
    output logic                               mem_read_valid,
    output logic [ADDR_BITS-1:0]               mem_read_address,
    input  logic                               mem_read_ready,
    input  logic [DATA_BITS-1:0]               mem_read_data,

    // downstream write channel
    output logic                               mem_write_valid,
    output logic [ADDR_BITS-1:0]               mem_write_address,
    output logic [DATA_BITS-1:0]               mem_write_data,
    input  logic                               mem_write_ready
);

    // Width of a consumer index; kept at least one bit for a single consumer.
    localparam int                c_idx_w = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [c_idx_w:0]  c_num   = (c_idx_w + 1)'(NUM_CONSUMERS);

    typedef enum logic [2:0] {
        ST_IDLE           = 3'd0,
        ST_READ_WAIT      = 3'd1,
        ST_WRITE_WAIT     = 3'd2,
        ST_READ_RELAYING  = 3'd3,
        ST_WRITE_RELAYING = 3'd4
    } state_t;

    state_t                             r_state;
    logic [c_idx_w-1:0]                 r_rr_ptr;
    logic [c_idx_w-1:0]                 r_cur;

    logic                               r_mem_read_valid;
    logic [ADDR_BITS-1:0]               r_mem_read_address;
    logic                               r_mem_write_valid;
    logic [ADDR_BITS-1:0]               r_mem_write_address;
    logic [DATA_BITS-1:0]               r_mem_write_data;
    logic [NUM_CONSUMERS-1:0]           r_consumer_read_ready;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] r_consumer_read_data;
    logic [NUM_CONSUMERS-1:0]           r_consumer_write_ready;

    logic                               w_grant_found;
    logic                               w_grant_is_read;
    logic [c_idx_w-1:0]                 w_grant_idx;
    logic [ADDR_BITS-1:0]               w_grant_rd_addr;
    logic [ADDR_BITS-1:0]               w_grant_wr_addr;
    logic [DATA_BITS-1:0]               w_grant_wr_data;
    logic [c_idx_w-1:0]                 w_next_ptr;

    // Round-robin search: walk offsets from the highest down so that the
    // consumer closest to r_rr_ptr (offset 0) is the one left selected.
    always_comb begin : p_arbiter
        logic [c_idx_w:0] v_sum;
        v_sum           = '0;
        w_grant_found   = 1'b0;
        w_grant_is_read = 1'b0;
        w_grant_idx     = '0;
        for (int i = NUM_CONSUMERS - 1; i >= 0; i--) begin
            v_sum = {1'b0, r_rr_ptr} + (c_idx_w + 1)'(i);
            if (v_sum >= c_num) begin
                v_sum = v_sum - c_num;
            end
            if (consumer_read_valid[v_sum[c_idx_w-1:0]] ||
                consumer_write_valid[v_sum[c_idx_w-1:0]]) begin
                w_grant_found   = 1'b1;
                w_grant_idx     = v_sum[c_idx_w-1:0];
                // a read on the same consumer takes priority over its write
                w_grant_is_read = consumer_read_valid[v_sum[c_idx_w-1:0]];
            end
        end
    end

    // Fetch the request payload of the consumer selected by the arbiter.
    always_comb begin
        w_grant_rd_addr = consumer_read_address [int'(w_grant_idx)*ADDR_BITS +: ADDR_BITS];
        w_grant_wr_addr = consumer_write_address[int'(w_grant_idx)*ADDR_BITS +: ADDR_BITS];
        w_grant_wr_data = consumer_write_data   [int'(w_grant_idx)*DATA_BITS +: DATA_BITS];
    end

    // Pointer value to install when the current consumer is released.
    always_comb begin
        if ({1'b0, r_cur} == (c_num - 1'b1)) begin
            w_next_ptr = '0;
        end else begin
            w_next_ptr = r_cur + 1'b1;
        end
    end

    // Main transaction FSM; every output is a register updated here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state                <= ST_IDLE;
            r_rr_ptr               <= '0;
            r_cur                  <= '0;
            r_mem_read_valid       <= 1'b0;
            r_mem_read_address     <= '0;
            r_mem_write_valid      <= 1'b0;
            r_mem_write_address    <= '0;
            r_mem_write_data       <= '0;
            r_consumer_read_ready  <= '0;
            r_consumer_read_data   <= '0;
            r_consumer_write_ready <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_found) begin
                        r_cur <= w_grant_idx;
                        if (w_grant_is_read) begin
                            r_mem_read_valid   <= 1'b1;
                            r_mem_read_address <= w_grant_rd_addr;
                            r_state            <= ST_READ_WAIT;
                        end else begin
                            r_mem_write_valid   <= 1'b1;
                            r_mem_write_address <= w_grant_wr_addr;
                            r_mem_write_data    <= w_grant_wr_data;
                            r_state             <= ST_WRITE_WAIT;
                        end
                    end
                end

                // Address is frozen while waiting; only the handshake moves on.
                ST_READ_WAIT: begin
                    if (mem_read_ready) begin
                        r_mem_read_valid                                     <= 1'b0;
                        r_consumer_read_data[int'(r_cur)*DATA_BITS +: DATA_BITS] <= mem_read_data;
                        r_consumer_read_ready[r_cur]                         <= 1'b1;
                        r_state                                              <= ST_READ_RELAYING;
                    end
                end

                ST_WRITE_WAIT: begin
                    if (mem_write_ready) begin
                        r_mem_write_valid             <= 1'b0;
                        r_consumer_write_ready[r_cur] <= 1'b1;
                        r_state                       <= ST_WRITE_RELAYING;
                    end
                end

                // Hold the completion until the consumer withdraws its request.
                ST_READ_RELAYING: begin
                    if (!consumer_read_valid[r_cur]) begin
                        r_consumer_read_ready[r_cur] <= 1'b0;
                        r_rr_ptr                     <= w_next_ptr;
                        r_state                      <= ST_IDLE;
                    end
                end

                ST_WRITE_RELAYING: begin
                    if (!consumer_write_valid[r_cur]) begin
                        r_consumer_write_ready[r_cur] <= 1'b0;
                        r_rr_ptr                      <= w_next_ptr;
                        r_state                       <= ST_IDLE;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem_read_valid       = r_mem_read_valid;
    assign mem_read_address     = r_mem_read_address;
    assign mem_write_valid      = r_mem_write_valid;
    assign mem_write_address    = r_mem_write_address;
    assign mem_write_data       = r_mem_write_data;
    assign consumer_read_ready  = r_consumer_read_ready;
    assign consumer_read_data   = r_consumer_read_data;
    assign consumer_write_ready = r_consumer_write_ready;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_data_mem_controller
//  Description : Self-checking bench for data_mem_controller. A reference
//                model predicts the round-robin service order and the data
//                each completion must carry; a monitor compares completions
//                against the predicted queue. A memory responder with random
//                latency serves the downstream channels.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_data_mem_controller;

    localparam int A = 8;
    localparam int D = 8;
    localparam int N = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     crv, cwv;
    logic [N*A-1:0]   cra, cwa;
    logic [N*D-1:0]   cwd;
    logic [N-1:0]     consumer_read_ready, consumer_write_ready;
    logic [N*D-1:0]   consumer_read_data;
    logic             mem_read_valid, mem_write_valid;
    logic [A-1:0]     mem_read_address, mem_write_address;
    logic [D-1:0]     mem_write_data, mem_read_data;
    logic             mem_read_ready, mem_write_ready;
    logic             rsp_rd_ready, rsp_wr_ready, spur_rd_ready;

    assign mem_read_ready  = rsp_rd_ready | spur_rd_ready;
    assign mem_write_ready = rsp_wr_ready;

    data_mem_controller #(.ADDR_BITS(A), .DATA_BITS(D), .NUM_CONSUMERS(N)) dut (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (crv),
        .consumer_read_address  (cra),
        .consumer_read_ready    (consumer_read_ready),
        .consumer_read_data     (consumer_read_data),
        .consumer_write_valid   (cwv),
        .consumer_write_address (cwa),
        .consumer_write_data    (cwd),
        .consumer_write_ready   (consumer_write_ready),
        .mem_read_valid         (mem_read_valid),
        .mem_read_address       (mem_read_address),
        .mem_read_ready         (mem_read_ready),
        .mem_read_data          (mem_read_data),
        .mem_write_valid        (mem_write_valid),
        .mem_write_address      (mem_write_address),
        .mem_write_data         (mem_write_data),
        .mem_write_ready        (mem_write_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_write;
        int           cons;
        logic [A-1:0] addr;
        logic [D-1:0] data;
    } exp_t;

    exp_t         exp_q[$];
    logic [D-1:0] tb_mem  [256];
    logic [D-1:0] ref_mem [256];
    int           model_ptr;
    int           n_checks = 0;
    int           n_pass   = 0;
    int           fixed_lat = -1;
    bit           resp_en   = 1'b1;
    logic [A-1:0] last_wr_addr;
    logic [D-1:0] last_wr_data;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endfunction

    // Reference model: serve pending requests in round-robin order from the
    // model pointer, read before write on the same consumer.
    task automatic model_round(input logic [N-1:0] rm, input logic [N-1:0] wm,
                               input logic [N*A-1:0] ra, input logic [N*A-1:0] wa,
                               input logic [N*D-1:0] wd);
        logic [N-1:0] pr, pw;
        int   c;
        exp_t e;
        pr = rm;
        pw = wm;
        while ((pr | pw) != '0) begin
            c = -1;
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (model_ptr + k) % N;
                if (c < 0 && (pr[idx] || pw[idx])) c = idx;
            end
            e.cons = c;
            if (pr[c]) begin
                e.is_write = 1'b0;
                e.addr     = ra[c*A +: A];
                e.data     = ref_mem[e.addr];
                pr[c]      = 1'b0;
            end else begin
                e.is_write       = 1'b1;
                e.addr           = wa[c*A +: A];
                e.data           = wd[c*D +: D];
                ref_mem[e.addr]  = e.data;
                pw[c]            = 1'b0;
            end
            exp_q.push_back(e);
            model_ptr = (c + 1) % N;
        end
    endtask

    // Drive a set of requests, releasing each one as soon as it completes.
    task automatic run_round(input logic [N-1:0] rm, input logic [N-1:0] wm,
                             input logic [N*A-1:0] ra, input logic [N*A-1:0] wa,
                             input logic [N*D-1:0] wd);
        model_round(rm, wm, ra, wa, wd);
        cra = ra; cwa = wa; cwd = wd;
        crv = rm; cwv = wm;
        for (int cyc = 0; cyc < 400 && (crv | cwv) != '0; cyc++) begin
            @(posedge clk); #1;
            for (int c = 0; c < N; c++) begin
                if (crv[c] && consumer_read_ready[c])  crv[c] = 1'b0;
                if (cwv[c] && consumer_write_ready[c]) cwv[c] = 1'b0;
            end
        end
        check("round_complete", {28'd0, crv | cwv}, 32'd0);
        crv = '0; cwv = '0;
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mem_rd_valid"}, {31'd0, mem_read_valid}, 32'd0);
        check({tag, "_mem_wr_valid"}, {31'd0, mem_write_valid}, 32'd0);
        check({tag, "_readies"}, {24'd0, consumer_read_ready, consumer_write_ready}, 32'd0);
        check({tag, "_rd_data"}, consumer_read_data, 32'd0);
        check({tag, "_addrs"}, {8'd0, mem_read_address, mem_write_address, mem_write_data}, 32'd0);
    endtask

    // Memory responder: random (or fixed) latency, one-cycle ready pulses.
    initial begin
        bit           rd_busy, wr_busy;
        int           rd_cnt, wr_cnt;
        logic [A-1:0] rd_first;
        logic [A+D-1:0] wr_first;
        rd_busy = 0; wr_busy = 0; rd_cnt = 0; wr_cnt = 0;
        rd_first = '0; wr_first = '0;
        rsp_rd_ready = 1'b0; rsp_wr_ready = 1'b0; mem_read_data = '0;
        forever begin
            @(posedge clk); #1;
            if (rsp_rd_ready) rsp_rd_ready = 1'b0;
            else if (mem_read_valid && resp_en) begin
                if (!rd_busy) begin
                    rd_busy  = 1;
                    rd_cnt   = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                    rd_first = mem_read_address;
                end
                if (rd_cnt == 0) begin
                    check("mem_rd_addr_stable", {24'd0, mem_read_address}, {24'd0, rd_first});
                    mem_read_data = tb_mem[mem_read_address];
                    rsp_rd_ready  = 1'b1;
                    rd_busy       = 0;
                end else rd_cnt--;
            end else if (!mem_read_valid) rd_busy = 0;

            if (rsp_wr_ready) rsp_wr_ready = 1'b0;
            else if (mem_write_valid && resp_en) begin
                if (!wr_busy) begin
                    wr_busy  = 1;
                    wr_cnt   = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
                    wr_first = {mem_write_address, mem_write_data};
                end
                if (wr_cnt == 0) begin
                    check("mem_wr_stable", {16'd0, mem_write_address, mem_write_data}, {16'd0, wr_first});
                    tb_mem[mem_write_address] = mem_write_data;
                    last_wr_addr = mem_write_address;
                    last_wr_data = mem_write_data;
                    rsp_wr_ready = 1'b1;
                    wr_busy      = 0;
                end else wr_cnt--;
            end else if (!mem_write_valid) wr_busy = 0;
        end
    end

    // Monitor: every rising completion is matched against the predicted queue.
    initial begin
        logic [N-1:0] prr, pwr;
        exp_t e;
        prr = '0; pwr = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                for (int c = 0; c < N; c++) begin
                    if ((consumer_read_ready[c] && !prr[c]) || (consumer_write_ready[c] && !pwr[c])) begin
                        check("ready_onehot", $countones(consumer_read_ready | consumer_write_ready), 32'd1);
                        if (exp_q.size() == 0) begin
                            n_checks++;
                            $display("FAIL spurious_completion: consumer %0d completed with nothing expected", c);
                        end else begin
                            e = exp_q.pop_front();
                            check("served_consumer", c, e.cons);
                            check("served_kind", {31'd0, consumer_write_ready[c]}, {31'd0, e.is_write});
                            if (!e.is_write)
                                check("read_data", {24'd0, consumer_read_data[c*D +: D]}, {24'd0, e.data});
                            else
                                check("write_payload", {16'd0, last_wr_addr, last_wr_data}, {16'd0, e.addr, e.data});
                        end
                    end
                end
            end
            prr = consumer_read_ready;
            pwr = consumer_write_ready;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [D-1:0] v;
        logic [N*A-1:0] ra, wa;
        logic [N*D-1:0] wd;
        logic [N-1:0] rm, wm, seen;
        int hi;

        for (int i = 0; i < 256; i++) begin
            v = D'($urandom);
            tb_mem[i] = v; ref_mem[i] = v;
        end
        crv = '0; cwv = '0; cra = '0; cwa = '0; cwd = '0; spur_rd_ready = 1'b0;
        model_ptr = 0;
        reset = 1'b1;
        #3;
        check_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // single read: consumer 2, addr 0x10, 3-cycle memory latency
        fixed_lat = 3;
        tb_mem[8'h10] = 8'hAB; ref_mem[8'h10] = 8'hAB;
        ra = '0; ra[2*A +: A] = 8'h10;
        model_round(4'b0100, 4'b0000, ra, '0, '0);
        cra = ra; crv = 4'b0100;
        @(posedge clk); #1;
        check("rd_grant_latency", {31'd0, mem_read_valid}, 32'd1);
        check("rd_grant_addr", {24'd0, mem_read_address}, 32'h10);
        for (int cyc = 0; cyc < 50 && !consumer_read_ready[2]; cyc++) begin
            @(posedge clk); #1;
        end
        repeat (2) begin @(posedge clk); #1; end
        check("rd_ready_held", {28'd0, consumer_read_ready}, 32'b0100);
        crv = '0;
        @(posedge clk); #1;
        check("rd_ready_drop", {28'd0, consumer_read_ready}, 32'd0);
        check("rd_data_hold", {24'd0, consumer_read_data[2*D +: D]}, 32'hAB);
        @(posedge clk); #1;

        // single write: consumer 0 writes 0x55 to 0x20
        fixed_lat = 2;
        wa = '0; wa[A-1:0] = 8'h20; wd = '0; wd[D-1:0] = 8'h55;
        run_round(4'b0000, 4'b0001, '0, wa, wd);
        check("wr_mem_effect", {24'd0, tb_mem[8'h20]}, 32'h55);

        // all four read from pointer 0, then from pointer 3 (wrap)
        fixed_lat = -1;
        reset = 1'b1; #1; reset = 1'b0; model_ptr = 0;
        @(posedge clk); #1;
        run_round(4'b1111, 4'b0000, $urandom, '0, '0);
        run_round(4'b0100, 4'b0000, $urandom, '0, '0);
        run_round(4'b1111, 4'b0000, $urandom, '0, '0);

        // consumer 1 reads and writes together
        run_round(4'b0010, 4'b0010, $urandom, $urandom, $urandom);

        // spurious memory ready while idle
        spur_rd_ready = 1'b1;
        @(posedge clk); #1;
        spur_rd_ready = 1'b0;
        check("spur_no_rd_valid", {31'd0, mem_read_valid}, 32'd0);
        check("spur_no_ready", {28'd0, consumer_read_ready | consumer_write_ready}, 32'd0);

        // consumer drops its request while the memory read is in flight
        fixed_lat = 3;
        ra = $urandom;
        model_round(4'b0010, 4'b0000, ra, '0, '0);
        cra = ra; crv = 4'b0010;
        for (int cyc = 0; cyc < 20 && !mem_read_valid; cyc++) begin
            @(posedge clk); #1;
        end
        crv = '0;
        hi = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (consumer_read_ready[1]) hi++;
        end
        check("drop_ready_one_cycle", hi, 32'd1);

        // reset during a pending memory read aborts it silently
        resp_en = 1'b0;
        cra = $urandom; crv = 4'b1000;
        for (int cyc = 0; cyc < 20 && !mem_read_valid; cyc++) begin
            @(posedge clk); #1;
        end
        check("abort_rd_issued", {31'd0, mem_read_valid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        check_all_zero("async_reset");
        crv = '0;
        @(posedge clk); #1;
        reset = 1'b0; model_ptr = 0; resp_en = 1'b1;
        spur_rd_ready = 1'b1;
        @(posedge clk); #1;
        spur_rd_ready = 1'b0;
        seen = '0;
        repeat (3) begin
            @(posedge clk); #1;
            seen = seen | consumer_read_ready;
        end
        check("abort_no_completion", {28'd0, seen}, 32'd0);

        // randomized traffic over a small address window to create hazards
        fixed_lat = -1;
        for (int r = 0; r < 40; r++) begin
            rm = N'($urandom); wm = N'($urandom);
            if ((rm | wm) == '0) rm = 4'b0001;
            for (int c = 0; c < N; c++) begin
                ra[c*A +: A] = A'($urandom_range(0, 15));
                wa[c*A +: A] = A'($urandom_range(0, 15));
                wd[c*D +: D] = D'($urandom);
            end
            run_round(rm, wm, ra, wa, wd);
        end

        repeat (5) @(posedge clk);
        #1;
        check("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
